ram_file_banked: RTL and testbench



---
 rtl/ram_file_banked.sv | 190 +++++++++++++++++++
 tb/tb_ram_file_banked.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_file_banked.sv
// Banked general-purpose register file for the PIC16F core.
//
// Forms the 9-bit effective address from either the direct operand {rp, addr7}
// or the indirect operand {irp, fsr} (addr7 == 0 selects INDF). It serves
// per-bank GPRs plus a shared window that is mirrored in every bank. Any other
// address is handed to the SFR/peripheral side. After reset, a sequencer
// zeroes every GPR byte while holding off the core with busy.
//
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   rp         STATUS RP1:RP0 (direct bank select)
//   irp        STATUS IRP (indirect bank select)
//   fsr        FSR value (indirect address)
//   addr7      instruction file address, 0 selects INDF
//   wr_en      write strobe
//   data_in    write data
//   data_out   registered read data
//   eff_addr   combinational effective address for the SFR decoder
//   ext_sel    eff_addr is neither GPR nor null-INDF
//   ext_wr_en  write strobe qualified for the SFR side
//   ext_rdata  SFR/peripheral read data for eff_addr
//   busy       post-reset clear sequence in progress
module ram_file_banked #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned GPR_START      = 'h20,
  parameter int unsigned GPR_LEN        = 80,
  parameter int unsigned SHARED_START   = 'h70,
  parameter int unsigned SHARED_LEN     = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rp,
  input  logic       irp,
  input  logic [7:0] fsr,
  input  logic [6:0] addr7,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [8:0] eff_addr,
  output logic       ext_sel,
  output logic       ext_wr_en,
  input  logic [7:0] ext_rdata,
  output logic       busy
);

  localparam int unsigned BankDepth = NUM_BANKS * GPR_LEN;
  localparam int unsigned Total     = BankDepth + SHARED_LEN;
  localparam int unsigned CntW      = $clog2(Total);
  localparam int unsigned BIdxW     = $clog2(BankDepth);
  localparam int unsigned SIdxW     = (SHARED_LEN > 1) ? $clog2(SHARED_LEN) : 1;

  localparam logic [7:0] GprLo    = 8'(GPR_START);
  localparam logic [7:0] GprHi    = 8'(GPR_START + GPR_LEN);
  localparam logic [7:0] SharedLo = 8'(SHARED_START);
  localparam logic [7:0] SharedHi = 8'(SHARED_START + SHARED_LEN);

  localparam logic [CntW-1:0] CntLast = CntW'(Total - 1);
  localparam logic [CntW-1:0] CntBank = CntW'(BankDepth);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_out_q, data_out_d;

  logic [7:0] banked_q [BankDepth];
  logic [7:0] shared_q [SHARED_LEN];

  logic [6:0]       off;
  logic [1:0]       bank;
  logic             null_indf;
  logic             hit_bank;
  logic             hit_shared;
  logic             gpr_we;
  logic             clr_bank_we;
  logic             clr_shared_we;
  logic [BIdxW-1:0] bank_idx;
  logic [SIdxW-1:0] shared_idx;
  logic [BIdxW-1:0] clr_bank_idx;
  logic [SIdxW-1:0] clr_shared_idx;
  logic [7:0]       rdata;

  // Effective address: address changes take effect in the same cycle.
  always_comb begin
    if (addr7 != 7'd0) begin
      eff_addr = {rp, addr7};
    end else begin
      eff_addr = {irp, fsr};
    end
    // Two-bank parts have no RP1/IRP decode.
    if (NUM_BANKS == 2) begin
      eff_addr[8] = 1'b0;
    end
  end

  assign off  = eff_addr[6:0];
  assign bank = eff_addr[8:7];

  // INDF pointing at INDF itself reads zero and swallows writes.
  assign null_indf  = (addr7 == 7'd0) && (fsr[6:0] == 7'd0);
  assign hit_bank   = !null_indf && ({1'b0, off} >= GprLo) && ({1'b0, off} < GprHi);
  assign hit_shared = !null_indf && ({1'b0, off} >= SharedLo) && ({1'b0, off} < SharedHi);

  assign busy      = (state_q == StClear);
  assign ext_sel   = !null_indf && !hit_bank && !hit_shared;
  assign ext_wr_en = wr_en & ext_sel & ~busy;

  assign bank_idx   = BIdxW'(32'(bank) * GPR_LEN + 32'(off) - GPR_START);
  assign shared_idx = SIdxW'(32'(off) - SHARED_START);

  // No array writes are allowed while rst is asserted.
  assign gpr_we        = wr_en && !busy && !rst;
  assign clr_bank_we   = busy && !rst && (cnt_q < CntBank);
  assign clr_shared_we = busy && !rst && !(cnt_q < CntBank);
  assign clr_bank_idx   = BIdxW'(cnt_q);
  assign clr_shared_idx = SIdxW'(cnt_q - CntBank);

  // Storage carries no reset; the clear sequencer is the initialiser. The
  // clear and core writes never collide because busy blocks core writes.
  always_ff @(posedge clk) begin
    if (clr_bank_we) begin
      banked_q[clr_bank_idx] <= 8'h00;
    end else if (gpr_we && hit_bank) begin
      banked_q[bank_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_shared_we) begin
      shared_q[clr_shared_idx] <= 8'h00;
    end else if (gpr_we && hit_shared) begin
      shared_q[shared_idx] <= data_in;
    end
  end

  // Read mux, write-first on a same-cycle GPR write.
  always_comb begin
    rdata = 8'h00;
    if (ext_sel) begin
      rdata = ext_rdata;
    end else if ((hit_bank || hit_shared) && gpr_we) begin
      rdata = data_in;
    end else if (hit_bank) begin
      rdata = banked_q[bank_idx];
    end else if (hit_shared) begin
      rdata = shared_q[shared_idx];
    end
  end

  assign data_out_d = busy ? 8'h00 : rdata;

  // Clear sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q      <= '0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_file_banked.sv
module tb_ram_file_banked;

  logic       clk;
  logic       rst;
  logic [1:0] rp;
  logic       irp;
  logic [7:0] fsr;
  logic [6:0] addr7;
  logic       wr_en;
  logic [7:0] data_in;
  logic [7:0] ext_rdata;

  logic [7:0] data_out,  d2_data_out;
  logic [8:0] eff_addr,  d2_eff_addr;
  logic       ext_sel,   d2_ext_sel;
  logic       ext_wr_en, d2_ext_wr_en;
  logic       busy,      d2_busy;

  int n_cmp;
  int n_err;
  logic [7:0] exp_q [$];

  ram_file_banked u_dut (
    .clk       (clk),
    .rst       (rst),
    .rp        (rp),
    .irp       (irp),
    .fsr       (fsr),
    .addr7     (addr7),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .eff_addr  (eff_addr),
    .ext_sel   (ext_sel),
    .ext_wr_en (ext_wr_en),
    .ext_rdata (ext_rdata),
    .busy      (busy)
  );

  ram_file_banked #(
    .NUM_BANKS (2)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .rp        (rp),
    .irp       (irp),
    .fsr       (fsr),
    .addr7     (addr7),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .data_out  (d2_data_out),
    .eff_addr  (d2_eff_addr),
    .ext_sel   (d2_ext_sel),
    .ext_wr_en (d2_ext_wr_en),
    .ext_rdata (ext_rdata),
    .busy      (d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one access, queue its expected read data, compare after the edge.
  task automatic step(input string tag, input logic [1:0] s_rp, input logic s_irp,
                      input logic [7:0] s_fsr, input logic [6:0] s_addr, input logic s_we,
                      input logic [7:0] s_din, input logic [7:0] s_exp);
    logic [7:0] e;
    rp      = s_rp;
    irp     = s_irp;
    fsr     = s_fsr;
    addr7   = s_addr;
    wr_en   = s_we;
    data_in = s_din;
    exp_q.push_back(s_exp);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    e = exp_q.pop_front();
    check(tag, {8'h00, data_out}, {8'h00, e});
  endtask

  task automatic dir(input string tag, input logic [8:0] a9, input logic s_we,
                     input logic [7:0] s_din, input logic [7:0] s_exp);
    step(tag, a9[8:7], 1'b0, 8'h00, a9[6:0], s_we, s_din, s_exp);
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_clear(input string tag);
    int cycles;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (busy && cycles < 1000);
    check(tag, 16'(cycles), 16'd336);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    rp        = 2'd0;
    irp       = 1'b0;
    fsr       = 8'h00;
    addr7     = 7'h20;
    wr_en     = 1'b0;
    data_in   = 8'h00;
    ext_rdata = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {8'h00, data_out}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0001);

    // ext write attempted during clear must not reach the SFR side
    addr7     = 7'h03;
    wr_en     = 1'b1;
    ext_rdata = 8'hFF;
    #1;
    check("busy_ext_sel", {15'h0, ext_sel}, 16'h0001);
    check("busy_ext_wr_en", {15'h0, ext_wr_en}, 16'h0000);

    rst = 1'b0;
    wait_clear("clear_len");
    check("busy_data_out", {8'h00, data_out}, 16'h0000);
    wr_en     = 1'b0;
    ext_rdata = 8'h00;

    dir("clr_020", 9'h020, 1'b0, 8'h00, 8'h00);
    dir("clr_0a0", 9'h0A0, 1'b0, 8'h00, 8'h00);
    dir("clr_1ef", 9'h1EF, 1'b0, 8'h00, 8'h00);
    dir("clr_070", 9'h070, 1'b0, 8'h00, 8'h00);

    // shared mirror and banking
    dir("wr_075", 9'h075, 1'b1, 8'h5A, 8'h5A);
    dir("mirror_1f5", 9'h1F5, 1'b0, 8'h00, 8'h5A);
    dir("wr_020", 9'h020, 1'b1, 8'h11, 8'h11);
    dir("wr_0a0", 9'h0A0, 1'b1, 8'h22, 8'h22);
    dir("rd_020", 9'h020, 1'b0, 8'h00, 8'h11);
    dir("rd_0a0", 9'h0A0, 1'b0, 8'h00, 8'h22);

    // indirect
    step("ind_wr_1a4", 2'd0, 1'b1, 8'hA4, 7'h00, 1'b1, 8'hC3, 8'hC3);
    dir("dir_rd_1a4", 9'h1A4, 1'b0, 8'h00, 8'hC3);
    irp   = 1'b0;
    fsr   = 8'h80;
    addr7 = 7'h00;
    #1;
    check("null_ext_sel", {15'h0, ext_sel}, 16'h0000);
    step("null_wr", 2'd0, 1'b0, 8'h80, 7'h00, 1'b1, 8'h99, 8'h00);
    step("null_rd", 2'd0, 1'b0, 8'h80, 7'h00, 1'b0, 8'h00, 8'h00);

    // bypass then follow-up read
    dir("byp_030", 9'h030, 1'b1, 8'h77, 8'h77);
    dir("rd_030", 9'h030, 1'b0, 8'h00, 8'h77);

    // external routing
    rp        = 2'd0;
    addr7     = 7'h03;
    ext_rdata = 8'h18;
    wr_en     = 1'b1;
    data_in   = 8'hEE;
    #1;
    check("ext_eff_addr", {7'h0, eff_addr}, 16'h0003);
    check("ext_sel", {15'h0, ext_sel}, 16'h0001);
    check("ext_wr_en", {15'h0, ext_wr_en}, 16'h0001);
    step("ext_rd", 2'd0, 1'b0, 8'h00, 7'h03, 1'b1, 8'hEE, 8'h18);
    ext_rdata = 8'h00;
    dir("keep_020", 9'h020, 1'b0, 8'h00, 8'h11);
    dir("keep_0a0", 9'h0A0, 1'b0, 8'h00, 8'h22);
    dir("keep_030", 9'h030, 1'b0, 8'h00, 8'h77);
    dir("keep_075", 9'h075, 1'b0, 8'h00, 8'h5A);
    dir("keep_1a4", 9'h1A4, 1'b0, 8'h00, 8'hC3);

    // reset in the middle of a clear restarts it from zero
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", {15'h0, busy}, 16'h0001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_data_out", {8'h00, data_out}, 16'h0000);
    rst = 1'b0;
    wait_clear("reclear_len");
    dir("reclr_020", 9'h020, 1'b0, 8'h00, 8'h00);
    dir("reclr_075", 9'h075, 1'b0, 8'h00, 8'h00);

    // two-bank address formation
    irp   = 1'b1;
    fsr   = 8'h20;
    addr7 = 7'h00;
    #1;
    check("nb2_ind_eff", {7'h0, d2_eff_addr}, 16'h0020);
    check("nb4_ind_eff", {7'h0, eff_addr}, 16'h0120);
    rp    = 2'd3;
    addr7 = 7'h24;
    #1;
    check("nb2_dir_eff", {7'h0, d2_eff_addr}, 16'h00A4);
    check("nb4_dir_eff", {7'h0, eff_addr}, 16'h01A4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
